mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller directly downstream of the EX/MEM pipeline register.
- Consumes the latched access fields (valid, read/write, address, store data) and sequences a single access to a multi-cycle data memory.
- Returns load data to the MEM/WB side.
- Drives the pipeline-wide stall that freezes the EX/MEM register and all upstream latches until the access completes.

Parameters:
- DATA_WIDTH, 16, width of load/store data.
- ADDR_WIDTH, 16, width of byte address.
- TIMEOUT, 64, maximum WAIT cycles before an access is abandoned with an error; must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- acc_valid  in  1  EX/MEM holds a live instruction
- acc_rd  in  1  load request
- acc_wr  in  1  store request
- acc_addr  in  ADDR_WIDTH  byte address
- acc_wdata  in  DATA_WIDTH  store data
- flush  in  1  squash the current instruction (branch mispredict)
- mem_en  out  1  memory request strobe
- mem_wr_en  out  1  1 = write, 0 = read; valid only with mem_en
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_done
- mem_done  in  1  access complete
- stall  out  1  freeze EX/MEM and upstream latches
- rd_data  out  DATA_WIDTH  registered load result
- rd_valid  out  1  one-cycle pulse: rd_data is new
- err  out  1  one-cycle pulse: misaligned, illegal or timed-out access

Behaviour:
- Reset: state=IDLE, timer=0, flush_pend=0, rd_data=0, rd_valid=0, err=0. Combinational outputs evaluate to 0 in IDLE with acc_valid=0.
- States: IDLE, WAIT, DONE.
- Request qualifier: req = acc_valid & (acc_rd ^ acc_wr) & ~acc_addr[0] & ~flush.
- IDLE, req=1:
  - mem_en=1 for exactly this cycle; mem_wr_en=acc_wr; mem_addr/mem_wdata pass through.
  - stall=1 (combinational); next=WAIT; timer cleared.
- IDLE, acc_valid & ~flush with (acc_rd&acc_wr, or (acc_rd|acc_wr) & acc_addr[0]):
  - No request is issued; err pulses next cycle; stall=0; stay IDLE.
- IDLE, otherwise: all outputs idle.
- WAIT:
  - mem_en=0; stall=1.
  - mem_done=1: if read and not flush_pend, capture mem_rdata into rd_data. Next=DONE.
  - mem_done=0: timer increments. At timer==TIMEOUT-1, err pulses next cycle and next=IDLE; timeout takes priority only when mem_done=0.
- flush during WAIT: an outstanding memory op is not cancelled. flush_pend is set, the access completes normally, but rd_data and rd_valid are not updated.
- DONE:
  - stall=0, letting EX/MEM advance at this edge.
  - rd_valid=1 this cycle for unsquashed reads only.
  - No new request is ever issued in DONE; next=IDLE; flush_pend cleared.
- Latency: minimum stall = 2 cycles (request cycle plus one WAIT cycle with mem_done). The load result is visible in DONE. Each access costs one non-stalled DONE cycle.
- Store with mem_done: rd_data is held and rd_valid stays 0.
- mem_done in IDLE or DONE is ignored.
- Reset asserted mid-WAIT forces IDLE immediately; the memory is expected to be reset concurrently.
- Address width and data width are fixed; no arithmetic other than the timer, which saturates at TIMEOUT-1.

Decomposition:
- Shared package mem_stage_pkg: state encoding constants (IDLE=2'b00, WAIT=2'b01, DONE=2'b10), default widths, TIMEOUT default.
- One sub-module, mem_wait_timer: clear, enable, terminal-count output, parameterised by TIMEOUT, async active-high rst.

Test Plan:
- Aligned load, addr=16'h0040, mem_done 3 cycles after mem_en, mem_rdata=16'hBEEF -> mem_en high 1 cycle; stall high 4 cycles; DONE cycle has stall=0, rd_valid=1, rd_data=16'hBEEF.
- Store addr=16'h0010, wdata=16'h1234, mem_done next cycle -> mem_en=1 and mem_wr_en=1 with matching addr/data; stall 2 cycles; rd_valid never 1; rd_data unchanged.
- Misaligned load addr=16'h0041 -> mem_en stays 0; err pulses 1 cycle; stall stays 0.
- acc_rd=acc_wr=1 -> err pulse; no request issued.
- Load issued, then flush asserted in WAIT, mem_done after 2 cycles -> access completes; rd_valid=0; rd_data keeps its previous value.
- mem_done never asserted with TIMEOUT=8 -> err pulses after 8 WAIT cycles; state returns to IDLE; stall drops. Also assert rst mid-WAIT -> immediate IDLE with all outputs 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-stage controller: state encoding and
// default widths/timeout used by the interface, controller and timer.
package mem_stage_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_TIMEOUT    = 64;

    // Controller states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter width able to hold TIMEOUT-1 (TIMEOUT is at least 2).
    function automatic int timer_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/response bus between the memory-stage controller and the
// multi-cycle data memory. The controller is the master.
interface mem_stage_ctrl_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  mem_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_done;

    modport master (
        output mem_en,
        output mem_wr_en,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_done
    );

    modport slave (
        input  mem_en,
        input  mem_wr_en,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_done
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory stage. Counts enabled cycles from zero
// and saturates at TIMEOUT-1, where the terminal-count output is high.
module mem_wait_timer
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int TW = timer_width(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_reg;

    // Clear wins over enable; counting stops once the terminal value is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: takes the access latched in EX/MEM, issues one
// request to a multi-cycle memory, stalls the pipeline until it finishes and
// returns load data. Malformed accesses and timeouts raise a one-cycle err.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_valid,
    input  logic                  acc_rd,
    input  logic                  acc_wr,
    input  logic [ADDR_WIDTH-1:0] acc_addr,
    input  logic [DATA_WIDTH-1:0] acc_wdata,
    input  logic                  flush,
    mem_stage_ctrl_if.master      mem,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  err
);
    state_t                state_reg;
    logic                  rd_op_reg;
    logic                  flush_pend_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;
    logic                  err_reg;

    logic req;
    logic bad_req;
    logic issue;
    logic squash;
    logic timer_tc;

    // A well-formed, unsquashed, halfword-aligned single access.
    assign req = acc_valid & (acc_rd ^ acc_wr) & ~acc_addr[0] & ~flush;

    // Live instruction that cannot be issued: both rd and wr, or misaligned.
    assign bad_req = acc_valid & ~flush &
                     ((acc_rd & acc_wr) | ((acc_rd | acc_wr) & acc_addr[0]));

    // Request strobe only from IDLE; gated by rst so a frozen pipeline holding
    // a live access cannot drive the memory while the controller is in reset.
    assign issue = (state_reg == IDLE) & req & ~rst;

    // A flush seen at any point of the wait, including the completion cycle,
    // suppresses the load writeback.
    assign squash = flush_pend_reg | flush;

    // Request bus and stall are combinational so the access starts in the
    // same cycle the instruction reaches EX/MEM.
    always_comb begin
        mem.mem_en    = issue;
        mem.mem_wr_en = issue & acc_wr;
        mem.mem_addr  = issue ? acc_addr  : '0;
        mem.mem_wdata = issue ? acc_wdata : '0;
        stall         = ~rst & (issue | (state_reg == WAIT));
    end

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg != WAIT),
        .enable ((state_reg == WAIT) & ~mem.mem_done),
        .tc     (timer_tc)
    );

    // Access sequencer with registered load result and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            rd_op_reg      <= 1'b0;
            flush_pend_reg <= 1'b0;
            rd_data_reg    <= '0;
            rd_valid_reg   <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    flush_pend_reg <= 1'b0;
                    if (req) begin
                        state_reg <= WAIT;
                        rd_op_reg <= acc_rd;
                    end else if (bad_req) begin
                        err_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem.mem_done) begin
                        state_reg      <= DONE;
                        flush_pend_reg <= squash;
                        if (rd_op_reg && !squash) begin
                            rd_data_reg  <= mem.mem_rdata;
                            rd_valid_reg <= 1'b1;
                        end
                    end else if (timer_tc) begin
                        state_reg      <= IDLE;
                        flush_pend_reg <= 1'b0;
                        err_reg        <= 1'b1;
                    end else begin
                        flush_pend_reg <= squash;
                    end
                end
                DONE: begin
                    state_reg      <= IDLE;
                    flush_pend_reg <= 1'b0;
                end
                default: begin
                    state_reg      <= IDLE;
                    flush_pend_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: table of single-access vectors followed
// by hand-written multi-cycle sequences (long load, flush, timeout, reset).
module tb_mem_stage_ctrl;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          acc_valid, acc_rd, acc_wr, flush;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          stall, rd_valid, err;
    logic [DW-1:0] rd_data;

    mem_stage_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_bus ();

    mem_stage_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_valid (acc_valid),
        .acc_rd    (acc_rd),
        .acc_wr    (acc_wr),
        .acc_addr  (acc_addr),
        .acc_wdata (acc_wdata),
        .flush     (flush),
        .mem       (mem_bus),
        .stall     (stall),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    typedef struct {
        logic          v, rd, wr, fl;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, rdata;
        logic          e_en, e_wr, e_stall, e_err;
    } vec_t;

    vec_t vecs[10];

    // Per-cycle samples captured by run_seq (cycle 0 = request cycle).
    logic          s_stall[0:15], s_en[0:15], s_rv[0:15], s_err[0:15];
    logic [DW-1:0] s_rdata[0:15];

    task automatic idle_inputs();
        acc_valid = 0; acc_rd = 0; acc_wr = 0; flush = 0;
        acc_addr = '0; acc_wdata = '0;
        mem_bus.mem_done = 0; mem_bus.mem_rdata = '0;
    endtask

    // Presents one access for a single cycle, then drives flush / mem_done
    // on the given cycle indices (-1 = never) and samples n cycles.
    task automatic run_seq(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] rdata, input int done_at,
                           input int flush_at, input int extra_done_at, input int n);
        @(posedge clk); #1;
        acc_valid = 1; acc_rd = rd; acc_wr = wr; acc_addr = addr; acc_wdata = 16'h5A5A;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            s_stall[c] = stall; s_en[c] = mem_bus.mem_en; s_rv[c] = rd_valid;
            s_err[c] = err; s_rdata[c] = rd_data;
            @(posedge clk); #1;
            if (c == 0) acc_valid = 0;
            flush = (c + 1 == flush_at);
            mem_bus.mem_done  = (c + 1 == done_at) || (c + 1 == extra_done_at);
            mem_bus.mem_rdata = (c + 1 == extra_done_at) ? 16'h0BAD : rdata;
        end
        idle_inputs();
    endtask

    function automatic int count_ones(input int which, input int n);
        int k = 0;
        for (int c = 0; c < n; c++) begin
            case (which)
                0: k += int'(s_stall[c]);
                1: k += int'(s_en[c]);
                2: k += int'(s_rv[c]);
                default: k += int'(s_err[c]);
            endcase
        end
        return k;
    endfunction

    logic [DW-1:0] exp_rd_data;

    initial begin
        //            v  rd wr fl addr      wdata     rdata     en wr st er
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0};
        vecs[1] = '{1'b1,1'b1,1'b0,1'b0,16'h0020,16'h0000,16'h1111,1'b1,1'b0,1'b1,1'b0};
        vecs[2] = '{1'b1,1'b0,1'b1,1'b0,16'h0010,16'h1234,16'h0000,1'b1,1'b1,1'b1,1'b0};
        vecs[3] = '{1'b1,1'b1,1'b0,1'b0,16'h0041,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1};
        vecs[4] = '{1'b1,1'b1,1'b1,1'b0,16'h0040,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1};
        vecs[5] = '{1'b1,1'b0,1'b1,1'b0,16'h0013,16'hFFFF,16'h0000,1'b0,1'b0,1'b0,1'b1};
        vecs[6] = '{1'b1,1'b0,1'b0,1'b0,16'h0030,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0};
        vecs[7] = '{1'b1,1'b1,1'b0,1'b1,16'h0030,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0};
        vecs[8] = '{1'b1,1'b1,1'b0,1'b1,16'h0031,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0};
        vecs[9] = '{1'b1,1'b1,1'b0,1'b0,16'h7FFE,16'h0000,16'hA5A5,1'b1,1'b0,1'b1,1'b0};

        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset stall", stall, 0);
        check("reset mem_en", mem_bus.mem_en, 0);
        check("reset rd_data", rd_data, 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset err", err, 0);
        exp_rd_data = '0;

        // Table: request-cycle decode, next-cycle err, completion with mem_done.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            acc_valid = vecs[i].v; acc_rd = vecs[i].rd; acc_wr = vecs[i].wr;
            flush = vecs[i].fl; acc_addr = vecs[i].addr; acc_wdata = vecs[i].wdata;
            @(negedge clk);
            check($sformatf("v%0d mem_en", i), mem_bus.mem_en, vecs[i].e_en);
            check($sformatf("v%0d mem_wr_en", i), mem_bus.mem_wr_en, vecs[i].e_wr);
            check($sformatf("v%0d stall", i), stall, vecs[i].e_stall);
            if (vecs[i].e_en) begin
                check($sformatf("v%0d mem_addr", i), mem_bus.mem_addr, vecs[i].addr);
                check($sformatf("v%0d mem_wdata", i), mem_bus.mem_wdata, vecs[i].wdata);
            end
            @(posedge clk); #1;
            idle_inputs();
            if (vecs[i].e_en) begin
                mem_bus.mem_done = 1; mem_bus.mem_rdata = vecs[i].rdata;
            end
            @(negedge clk);
            check($sformatf("v%0d err", i), err, vecs[i].e_err);
            check($sformatf("v%0d wait stall", i), stall, vecs[i].e_en);
            if (vecs[i].e_en) begin
                @(posedge clk); #1;
                idle_inputs();
                if (vecs[i].rd) exp_rd_data = vecs[i].rdata;
                @(negedge clk);
                check($sformatf("v%0d done stall", i), stall, 0);
                check($sformatf("v%0d rd_valid", i), rd_valid, vecs[i].rd);
                check($sformatf("v%0d rd_data", i), rd_data, exp_rd_data);
            end
        end

        // Load with mem_done three cycles after the request; a stray mem_done
        // in DONE must be ignored.
        run_seq(1'b1, 1'b0, 16'h0040, 16'hBEEF, 3, -1, 4, 7);
        check("ldA stall cycles", count_ones(0, 7), 4);
        check("ldA mem_en cycles", count_ones(1, 7), 1);
        check("ldA done stall", s_stall[4], 0);
        check("ldA rd_valid", s_rv[4], 1);
        check("ldA rd_data", s_rdata[4], 16'hBEEF);
        check("ldA rd_valid pulses", count_ones(2, 7), 1);
        check("ldA rd_data held", s_rdata[6], 16'hBEEF);
        check("ldA no err", count_ones(3, 7), 0);

        // Flush during WAIT: access completes but writeback is squashed.
        run_seq(1'b1, 1'b0, 16'h0044, 16'hDEAD, 2, 1, -1, 5);
        check("fl stall cycles", count_ones(0, 5), 3);
        check("fl done stall", s_stall[3], 0);
        check("fl rd_valid pulses", count_ones(2, 5), 0);
        check("fl rd_data kept", s_rdata[4], 16'hBEEF);

        // Following load must be unaffected by the earlier flush.
        run_seq(1'b1, 1'b0, 16'h0050, 16'h5555, 1, -1, -1, 4);
        check("ldB rd_valid", s_rv[2], 1);
        check("ldB rd_data", s_rdata[2], 16'h5555);

        // No mem_done: err after TIMEOUT wait cycles, then back to IDLE.
        run_seq(1'b1, 1'b0, 16'h0060, 16'h0000, -1, -1, -1, 12);
        check("to stall cycles", count_ones(0, 12), TO + 1);
        check("to err cycle", s_err[TO + 1], 1);
        check("to err pulses", count_ones(3, 12), 1);
        check("to stall dropped", s_stall[TO + 1], 0);
        check("to rd_valid", count_ones(2, 12), 0);

        // mem_done while IDLE is ignored.
        @(posedge clk); #1;
        mem_bus.mem_done = 1; mem_bus.mem_rdata = 16'h9999;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("idle done rd_valid", rd_valid, 0);
        check("idle done stall", stall, 0);

        // Reset in the middle of WAIT, with the access still held upstream.
        @(posedge clk); #1;
        acc_valid = 1; acc_rd = 1; acc_addr = 16'h0070;
        @(negedge clk);
        check("rstw issue stall", stall, 1);
        @(negedge clk);
        check("rstw wait stall", stall, 1);
        #2 rst = 1;
        #1;
        check("rstw stall", stall, 0);
        check("rstw mem_en", mem_bus.mem_en, 0);
        check("rstw mem_addr", mem_bus.mem_addr, 0);
        check("rstw rd_data", rd_data, 0);
        check("rstw err", err, 0);
        idle_inputs();
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("post rst stall", stall, 0);

        // Recovery: a normal load completes after reset.
        run_seq(1'b1, 1'b0, 16'h0072, 16'h7777, 1, -1, -1, 4);
        check("rec rd_valid", s_rv[2], 1);
        check("rec rd_data", s_rdata[2], 16'h7777);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
